// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl
// Applies hazard-unit stall/flush decisions to the five-stage pipeline:
// drives register load enables and bubble injects, tracks per-stage valid
// bits, and sequences the fetch redirect handshake after a mispredict flush.
// Optional feature: define PIPE_CTRL_PERF_EN to add the performance counters
// perf_stall_cycles and perf_flush_count.

module pipe_stage_ctrl #(
    parameter int XLEN          = 32,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      hazard_stall,
    input  logic            hazard_flush,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            if_valid,
    input  logic            mem_busy,
    input  logic            redirect_ready,
    output logic            if_id_en,
    output logic            id_ex_en,
    output logic            ex_mem_en,
    output logic            mem_wb_en,
    output logic            id_ex_bubble,
    output logic            ex_mem_bubble,
    output logic            mem_wb_bubble,
    output logic            id_valid,
    output logic            ex_valid,
    output logic            mem_valid,
    output logic            wb_valid,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic [1:0]      pipe_state,
    output logic            stall_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_flush_count
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_STALL    = 2'b01,
        ST_FREEZE   = 2'b10,
        ST_REDIRECT = 2'b11
    } state_t;

    localparam logic [15:0] WD_MAX   = 16'hFFFF;
    localparam logic [15:0] WD_LIMIT = 16'(STALL_TIMEOUT);

    state_t          state_q, state_d;
    logic            id_d, ex_d, mem_d, wb_d;
    logic            rv_d;
    logic [XLEN-1:0] pc_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            flush_now;
    logic [XLEN-1:0] flush_pc;
    logic            stall_ex, stall_mem;
    logic [15:0]     wd_cnt, wd_next;

    // A flush that arrived during a freeze is replayed as if it arrived now;
    // a live flush on the same cycle is newer and takes precedence.
    assign flush_now = hazard_flush | pend_q;
    assign flush_pc  = hazard_flush ? redirect_pc : pend_pc_q;
    assign stall_mem = hazard_stall[1];
    assign stall_ex  = (hazard_stall == 2'b01);
    assign pipe_state = state_q;

    // Priority decode: reset, memory freeze, flush, stall, then normal run.
    // redirect_valid doubles as the "redirect in progress" marker, which
    // also remembers that a freeze was entered from REDIRECT.
    always_comb begin
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_en     = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        mem_wb_bubble = 1'b0;
        id_d          = id_valid;
        ex_d          = ex_valid;
        mem_d         = mem_valid;
        wb_d          = wb_valid;
        rv_d          = redirect_valid;
        pc_d          = redirect_pc_o;
        pend_d        = pend_q;
        pend_pc_d     = pend_pc_q;
        state_d       = state_q;

        if (reset) begin
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (mem_busy) begin
            state_d = ST_FREEZE;
            if (hazard_flush) begin
                pend_d    = 1'b1;
                pend_pc_d = redirect_pc;
            end
        end else if (flush_now) begin
            id_ex_en     = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_en    = 1'b1;
            mem_wb_en    = 1'b1;
            id_d         = 1'b0;
            ex_d         = 1'b0;
            mem_d        = ex_valid;
            wb_d         = mem_valid;
            rv_d         = 1'b1;
            pc_d         = flush_pc;
            pend_d       = 1'b0;
            state_d      = ST_REDIRECT;
        end else begin
            if (stall_mem) begin
                mem_wb_en     = 1'b1;
                mem_wb_bubble = 1'b1;
                wb_d          = 1'b0;
            end else if (stall_ex) begin
                ex_mem_en     = 1'b1;
                ex_mem_bubble = 1'b1;
                mem_wb_en     = 1'b1;
                mem_d         = 1'b0;
                wb_d          = mem_valid;
            end else begin
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
                ex_d      = id_valid;
                mem_d     = ex_valid;
                wb_d      = mem_valid;
            end

            if (redirect_valid) begin
                id_d = 1'b0;
                if (redirect_ready) begin
                    rv_d    = 1'b0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_REDIRECT;
                end
            end else begin
                if (!stall_mem && !stall_ex) begin
                    if_id_en = 1'b1;
                    id_d     = if_valid;
                end
                state_d = (hazard_stall != 2'b00) ? ST_STALL : ST_RUN;
            end
        end
    end

    // State, valid bits, redirect request and pending-flush registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RUN;
            id_valid       <= 1'b0;
            ex_valid       <= 1'b0;
            mem_valid      <= 1'b0;
            wb_valid       <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc_o  <= '0;
            pend_q         <= 1'b0;
            pend_pc_q      <= '0;
        end else begin
            state_q        <= state_d;
            id_valid       <= id_d;
            ex_valid       <= ex_d;
            mem_valid      <= mem_d;
            wb_valid       <= wb_d;
            redirect_valid <= rv_d;
            redirect_pc_o  <= pc_d;
            pend_q         <= pend_d;
            pend_pc_q      <= pend_pc_d;
        end
    end

    // Saturating increment so a very long stall cannot wrap the watchdog.
    assign wd_next = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 16'd1;

    // Watchdog: count consecutive non-RUN cycles, latch a sticky flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt        <= '0;
            stall_timeout <= 1'b0;
        end else if (state_q == ST_RUN) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_next;
            if (wd_next >= WD_LIMIT) begin
                stall_timeout <= 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic flush_accept;
    assign flush_accept = !reset && !mem_busy && flush_now;

    // Free-running performance counters; they wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (state_q == ST_STALL || state_q == ST_FREEZE) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (flush_accept) begin
                perf_flush_count <= perf_flush_count + 32'd1;
            end
        end
    end
`endif

endmodule
